// File: rtl/tt_sweep_eval.sv
// tt_sweep_eval: run-time loadable N_IN-input / N_OUT-output truth table.
// In IDLE the table is evaluated directly from in_vec (1-cycle latency).
// A sweep steps through every input combination, holding each vector for
// STEP_CYC cycles, counts 1s per output channel and pulses done at the end.
// Optional build macro TT_SWEEP_SIGNATURE_EN adds a 16-bit rotate-XOR
// response signature on sig_out; without it sig_out is tied to zero.
module tt_sweep_eval #(
  parameter int N_IN     = 4,
  parameter int N_OUT    = 3,
  parameter int STEP_CYC = 10
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        wr_en,
  input  logic [N_IN-1:0]             wr_addr,
  input  logic [N_OUT-1:0]            wr_data,
  input  logic [N_IN-1:0]             in_vec,
  input  logic                        start,
  input  logic                        abort,
  output logic [N_IN-1:0]             vec_out,
  output logic [N_OUT-1:0]            y,
  output logic                        busy,
  output logic                        done,
  output logic [N_OUT*(N_IN+1)-1:0]   ones_cnt,
  output logic [15:0]                 sig_out
);

  localparam int DEPTH  = 1 << N_IN;
  localparam int CNT_W  = N_IN + 1;
  localparam int STEP_W = (STEP_CYC > 1) ? $clog2(STEP_CYC) : 1;
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_CYC - 1);
  localparam logic [N_IN-1:0]   VEC_ZERO  = '0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SWEEP,
    ST_DONE
  } state_t;

  state_t             state;
  logic [N_OUT-1:0]   tbl [DEPTH];
  logic [STEP_W-1:0]  step_cnt;

  logic [N_IN-1:0]    vec_nxt;
  logic [N_OUT-1:0]   y_in;
  logic [N_OUT-1:0]   y_first;
  logic [N_OUT-1:0]   y_next;
  logic               sweep_go;
  logic               step_end;
  logic               last_vec;

  // Table read ports and step/sweep decode shared by the control logic
  always_comb begin
    vec_nxt  = vec_out + 1'b1;
    y_in     = tbl[in_vec];
    y_first  = tbl[VEC_ZERO];
    y_next   = tbl[vec_nxt];
    sweep_go = start & ~abort;
    step_end = (step_cnt == STEP_LAST);
    last_vec = &vec_out;
  end

  // Table storage: cleared by reset, writable only while idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        tbl[i] <= '0;
      end
    end else if (state == ST_IDLE && wr_en) begin
      tbl[wr_addr] <= wr_data;
    end
  end

  // Sweep controller with registered vector, table output and 1s counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      vec_out  <= '0;
      y        <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      ones_cnt <= '0;
      step_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (sweep_go) begin
            state    <= ST_SWEEP;
            busy     <= 1'b1;
            vec_out  <= '0;
            y        <= y_first;
            step_cnt <= '0;
            for (int unsigned k = 0; k < N_OUT; k++) begin
              ones_cnt[k*CNT_W +: CNT_W] <= CNT_W'(y_first[k]);
            end
          end else begin
            vec_out <= in_vec;
            y       <= y_in;
          end
        end
        ST_SWEEP: begin
          if (abort) begin
            state    <= ST_IDLE;
            busy     <= 1'b0;
            step_cnt <= '0;
          end else if (step_end) begin
            step_cnt <= '0;
            if (last_vec) begin
              state <= ST_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              vec_out <= vec_nxt;
              y       <= y_next;
              for (int unsigned k = 0; k < N_OUT; k++) begin
                ones_cnt[k*CNT_W +: CNT_W] <= ones_cnt[k*CNT_W +: CNT_W] + CNT_W'(y_next[k]);
              end
            end
          end else begin
            step_cnt <= step_cnt + 1'b1;
          end
        end
        ST_DONE: begin
          done  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef TT_SWEEP_SIGNATURE_EN
  // Response signature: seeded from table[0] at start, folded in per vector step
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig_out <= '0;
    end else if (state == ST_IDLE && sweep_go) begin
      sig_out <= 16'hFFFF ^ 16'(y_first);
    end else if (state == ST_SWEEP && !abort && step_end && !last_vec) begin
      sig_out <= {sig_out[14:0], sig_out[15]} ^ 16'(y_next);
    end
  end
`else
  assign sig_out = '0;
`endif

endmodule

// File: tb/tb_tt_sweep_eval.sv
// Scoreboard bench for tt_sweep_eval (N_IN=4, N_OUT=3, STEP_CYC=2).
// Stimulus pushes expected direct-evaluation results and expected sweep
// outcomes into queues; a monitor pops and compares them as the DUT
// presents registered outputs and as each sweep ends.
module tb_tt_sweep_eval;

  localparam int N_IN  = 4;
  localparam int N_OUT = 3;
  localparam int STEP  = 2;
  localparam int DEPTH = 16;
  localparam int CW    = 5;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              wr_en;
  logic [N_IN-1:0]   wr_addr;
  logic [N_OUT-1:0]  wr_data;
  logic [N_IN-1:0]   in_vec;
  logic              start;
  logic              abort;
  logic [N_IN-1:0]   vec_out;
  logic [N_OUT-1:0]  y;
  logic              busy;
  logic              done;
  logic [14:0]       ones_cnt;
  logic [15:0]       sig_out;

  tt_sweep_eval #(
    .N_IN     (N_IN),
    .N_OUT    (N_OUT),
    .STEP_CYC (STEP)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .in_vec   (in_vec),
    .start    (start),
    .abort    (abort),
    .vec_out  (vec_out),
    .y        (y),
    .busy     (busy),
    .done     (done),
    .ones_cnt (ones_cnt),
    .sig_out  (sig_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] vec;
    logic [2:0] yv;
    logic       bsy;
  } eval_t;

  typedef struct {
    logic        dn;
    logic [14:0] ones;
    logic [15:0] sig;
    int          len;
  } sweep_t;

  eval_t      eval_q[$];
  sweep_t     sweep_q[$];
  logic [2:0] model [DEPTH];
  int         checks = 0;
  int         failures = 0;
  int         exp_dones = 0;
  int         done_seen = 0;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic logic [2:0] spec_entry(input int i);
    logic [3:0] iv;
    iv = 4'(i);
    return {(i == 15), (i >= 8), ^iv};
  endfunction

  // Expected outcome of a sweep covering vectors 0..last of the current table
  function automatic sweep_t predict(input int last);
    sweep_t     r;
    int         cnt;
    logic [15:0] s;
    r.ones = '0;
    for (int k = 0; k < N_OUT; k++) begin
      cnt = 0;
      for (int i = 0; i <= last; i++) cnt += int'(model[i][k]);
      r.ones[k*CW +: CW] = 5'(cnt);
    end
    s = 16'hFFFF ^ {13'b0, model[0]};
    for (int i = 1; i <= last; i++) s = {s[14:0], s[15]} ^ {13'b0, model[i]};
`ifdef TT_SWEEP_SIGNATURE_EN
    r.sig = s;
`else
    r.sig = 16'h0000;
`endif
    r.dn  = (last == DEPTH - 1);
    r.len = (last == DEPTH - 1) ? DEPTH * STEP : -1;
    return r;
  endfunction

  // Monitor: direct-eval scoreboard, per-cycle sweep progress, sweep-end results
  initial begin
    eval_t  e;
    sweep_t s;
    logic   prev_busy;
    int     cur_len;
    prev_busy = 1'b0;
    cur_len   = 0;
    forever begin
      @(posedge clk);
      #1;
      if (eval_q.size() > 0) begin
        e = eval_q.pop_front();
        chk("eval_vec", 32'(vec_out), 32'(e.vec));
        chk("eval_y", 32'(y), 32'(e.yv));
        chk("eval_busy", 32'(busy), 32'(e.bsy));
      end
      if (busy === 1'b1) begin
        chk("sweep_vec", 32'(vec_out), 32'(cur_len / STEP));
        chk("sweep_y", 32'(y), 32'(model[vec_out]));
        cur_len++;
      end else if (prev_busy) begin
        if (sweep_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sweep_unexpected: got sweep end expected none at %0t", $time);
        end else begin
          s = sweep_q.pop_front();
          chk("sweep_done", 32'(done), 32'(s.dn));
          chk("sweep_ones", 32'(ones_cnt), 32'(s.ones));
          chk("sweep_sig", 32'(sig_out), 32'(s.sig));
          if (s.len >= 0) chk("sweep_len", 32'(cur_len), 32'(s.len));
`ifdef TT_SWEEP_SIGNATURE_EN
          if (s.dn) begin
            checks++;
            if (sig_out == 16'h0000) begin
              failures++;
              $display("FAIL sig_nonzero: got %0h expected nonzero", sig_out);
            end
          end
`endif
        end
        cur_len = 0;
      end
      if (done === 1'b1) done_seen++;
      prev_busy = (busy === 1'b1);
    end
  end

  task automatic idle_step(input logic [3:0] v, input logic we, input logic [3:0] a, input logic [2:0] d);
    eval_t e;
    @(negedge clk);
    in_vec  = v;
    wr_en   = we;
    wr_addr = a;
    wr_data = d;
    start   = 1'b0;
    abort   = 1'b0;
    e.vec = v;
    e.yv  = model[v];
    e.bsy = 1'b0;
    eval_q.push_back(e);
    if (we) model[a] = d;
  endtask

  // last = final vector expected to be counted; negative = sweep killed by reset
  task automatic begin_sweep(input int last);
    sweep_t z;
    @(negedge clk);
    wr_en  = 1'b0;
    in_vec = 4'($urandom);
    start  = 1'b1;
    abort  = 1'b0;
    if (last < 0) begin
      z.dn = 1'b0; z.ones = '0; z.sig = '0; z.len = -1;
      sweep_q.push_back(z);
    end else begin
      sweep_q.push_back(predict(last));
      if (last == DEPTH - 1) exp_dones++;
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_vec(input int v);
    int n;
    n = 0;
    while (!(busy === 1'b1 && vec_out == 4'(v)) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++;
      failures++;
      $display("FAIL wait_vec_timeout: got vec_out=%0d expected %0d", vec_out, v);
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy === 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) begin
      checks++;
      failures++;
      $display("FAIL wait_idle_timeout: got busy=%0b expected 0", busy);
    end
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    eval_t e;
    rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    in_vec = '0; start = 1'b0; abort = 1'b0;
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
    repeat (3) @(negedge clk);
    chk("rst_vec", 32'(vec_out), 0);
    chk("rst_y", 32'(y), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_ones", 32'(ones_cnt), 0);
    chk("rst_sig", 32'(sig_out), 0);
    rst_n = 1'b1;

    idle_step(4'hA, 1'b0, 4'h0, 3'h0);

    // Load the reference table while evaluating random vectors
    for (int i = 0; i < DEPTH; i++) idle_step(4'($urandom), 1'b1, 4'(i), spec_entry(i));
    // Same-cycle write/read of one entry: old value first, new value next
    idle_step(4'h5, 1'b1, 4'h5, 3'b111);
    idle_step(4'h5, 1'b0, 4'h0, 3'h0);
    idle_step(4'h5, 1'b1, 4'h5, spec_entry(5));
    idle_step(4'h5, 1'b0, 4'h0, 3'h0);
    idle_step(4'hF, 1'b0, 4'h0, 3'h0);

    // Full sweep with a redundant start pulse mid-sweep
    begin_sweep(DEPTH - 1);
    repeat (7) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle();
    idle_step(4'h3, 1'b0, 4'h0, 3'h0);

    // Abort at vector 5 with a write attempt during the sweep
    begin_sweep(5);
    wr_en = 1'b1; wr_addr = 4'h3; wr_data = ~model[3];
    @(negedge clk);
    wr_en = 1'b0;
    wait_vec(5);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    wait_idle();
    idle_step(4'h3, 1'b0, 4'h0, 3'h0);

    // start and abort together in IDLE: no sweep
    @(negedge clk);
    in_vec = 4'h7; start = 1'b1; abort = 1'b1; wr_en = 1'b0;
    e.vec = 4'h7; e.yv = model[7]; e.bsy = 1'b0;
    eval_q.push_back(e);
    idle_step(4'h2, 1'b0, 4'h0, 3'h0);
    idle_step(4'h9, 1'b0, 4'h0, 3'h0);

    // Random tables, direct evaluations and full sweeps
    repeat (2) begin
      for (int i = 0; i < DEPTH; i++) idle_step(4'($urandom), 1'b1, 4'(i), 3'($urandom));
      repeat (6) idle_step(4'($urandom), 1'b0, 4'h0, 3'h0);
      begin_sweep(DEPTH - 1);
      wait_idle();
    end

    // Reset mid-sweep at vector 9
    begin_sweep(-1);
    wait_vec(9);
    rst_n = 1'b0;
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
    #1;
    chk("midrst_vec", 32'(vec_out), 0);
    chk("midrst_y", 32'(y), 0);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_done", 32'(done), 0);
    chk("midrst_ones", 32'(ones_cnt), 0);
    chk("midrst_sig", 32'(sig_out), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < DEPTH; i++) idle_step(4'(i), 1'b0, 4'h0, 3'h0);

    repeat (3) @(negedge clk);
    chk("done_count", 32'(done_seen), 32'(exp_dones));
    chk("queues_drained", 32'(eval_q.size() + sweep_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
